// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter with parallel load, exposing per-bit JK excitation.
// Build option: define JK_CNT_SAT_EN to saturate at the count limits instead of wrapping.
module jk_updown_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             ld,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic [WIDTH-1:0] j_exc,
   output logic [WIDTH-1:0] k_exc,
   output logic             tc,
   output logic             ld_err
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] qb_q, qb_d;
   logic             tc_q, tc_d;
   logic             ld_err_q, ld_err_d;

   always_comb begin
      q_d      = q_q;
      tc_d     = 1'b0;
      ld_err_d = 1'b0;
      if (ld) begin
         // Comparison done at int width so MODULUS == 2**WIDTH never flags.
         if (int'(din) >= MODULUS) begin
            q_d      = MAX_V;
            ld_err_d = 1'b1;
         end else begin
            q_d = din;
         end
      end else if (en) begin
         if (up) begin
            if (q_q == MAX_V) begin
`ifdef JK_CNT_SAT_EN
               q_d  = q_q;
`else
               q_d  = '0;
               tc_d = 1'b1;
`endif
            end else begin
               q_d = q_q + WIDTH'(1);
`ifdef JK_CNT_SAT_EN
               tc_d = (q_d == MAX_V);
`endif
            end
         end else begin
            if (q_q == '0) begin
`ifdef JK_CNT_SAT_EN
               q_d  = q_q;
`else
               q_d  = MAX_V;
               tc_d = 1'b1;
`endif
            end else begin
               q_d = q_q - WIDTH'(1);
`ifdef JK_CNT_SAT_EN
               tc_d = (q_d == '0);
`endif
            end
         end
      end
      qb_d = ~q_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q      <= '0;
         qb_q     <= '1;
         tc_q     <= 1'b0;
         ld_err_q <= 1'b0;
      end else begin
         q_q      <= q_d;
         qb_q     <= qb_d;
         tc_q     <= tc_d;
         ld_err_q <= ld_err_d;
      end
   end

   // Don't-cares resolve to 0: J only sets 0->1 bits, K only clears 1->0 bits.
   assign j_exc  = rst_n ? (~q_q &  q_d) : '0;
   assign k_exc  = rst_n ? ( q_q & ~q_d) : '0;

   assign q      = q_q;
   assign qb     = qb_q;
   assign tc     = tc_q;
   assign ld_err = ld_err_q;

endmodule
